// File: rtl/arbiter_n_rr_reg.sv
// N-input round-robin arbiter with valid/ready on every input and a registered output stage.
// Optional packet locking (a granted requester keeps the grant until in_last) is enabled by ARBITER_RR_PACKET_LOCK_EN.
module arbiter_n_rr_reg #(
  parameter int N_INPUTS       = 4,
  parameter int DWIDTH         = 16,
  parameter int FIRST_PRIORITY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_INPUTS-1:0]          in_valid,
  input  logic [N_INPUTS*DWIDTH-1:0]   in_data,
  input  logic [N_INPUTS-1:0]          in_last,
  output logic [N_INPUTS-1:0]          in_ready,
  output logic                         out_valid,
  output logic [DWIDTH-1:0]            out_data,
  output logic [$clog2(N_INPUTS)-1:0]  out_src,
  input  logic                         out_ready
);

  localparam int SW = $clog2(N_INPUTS);
  // Reset last_grant to the index just before FIRST_PRIORITY, so the first search starts at FIRST_PRIORITY.
  localparam logic [SW-1:0] LAST_GRANT_RST = SW'((FIRST_PRIORITY + N_INPUTS - 1) % N_INPUTS);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [SW-1:0]     r_src;
  logic [SW-1:0]     r_last_grant;

  logic              w_slot_free;
  logic              w_found;
  logic [SW-1:0]     w_search_idx;
  logic [SW-1:0]     w_winner;
  logic              w_win_valid;
  logic              w_accept;
  logic              w_grant_update;
  logic [DWIDTH-1:0] w_win_data;

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_src     = r_src;
  assign w_slot_free = !r_valid || out_ready;

  // Round-robin search: first valid requester after last_grant, wrapping modulo N_INPUTS.
  always_comb begin
    w_found      = 1'b0;
    w_search_idx = {SW{1'b0}};
    for (int k = 1; k <= N_INPUTS; k++) begin
      int  idx;
      logic hit;
      idx          = (int'(r_last_grant) + k) % N_INPUTS;
      hit          = in_valid[idx] && !w_found;
      w_search_idx = hit ? SW'(idx) : w_search_idx;
      w_found      = w_found || hit;
    end
  end

`ifdef ARBITER_RR_PACKET_LOCK_EN
  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_lock_idx;
  logic          w_lock_active;

  // State register and locked-requester index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARB;
      r_lock_idx <= {SW{1'b0}};
    end else begin
      r_state <= w_state_next;
      if (w_accept && !w_lock_active) begin
        r_lock_idx <= w_winner;
      end else begin
        r_lock_idx <= r_lock_idx;
      end
    end
  end

  // Next-state: lock on a non-final beat, unlock on the final beat of the locked packet.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_accept && !in_last[w_winner]) begin
          w_state_next = ST_LOCKED;
        end else begin
          w_state_next = ST_ARB;
        end
      end
      ST_LOCKED: begin
        if (w_accept && in_last[r_lock_idx]) begin
          w_state_next = ST_ARB;
        end else begin
          w_state_next = ST_LOCKED;
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  // FSM outputs: whether the grant is pinned to the locked requester.
  always_comb begin
    w_lock_active = 1'b0;
    case (r_state)
      ST_ARB:    w_lock_active = 1'b0;
      ST_LOCKED: w_lock_active = 1'b1;
      default:   w_lock_active = 1'b0;
    endcase
  end

  assign w_winner       = w_lock_active ? r_lock_idx : w_search_idx;
  assign w_win_valid    = w_lock_active || w_found;
  // The rotation pointer advances only when a packet completes.
  assign w_grant_update = w_accept && in_last[w_winner];
`else
  logic w_unused_last;

  assign w_unused_last  = ^in_last;
  assign w_winner       = w_search_idx;
  assign w_win_valid    = w_found;
  assign w_grant_update = w_accept;
`endif

  assign w_accept   = !rst && w_win_valid && in_valid[w_winner] && w_slot_free;
  assign w_win_data = in_data[int'(w_winner)*DWIDTH +: DWIDTH];

  // Ready goes to the current winner only, gated by output-slot availability and reset.
  always_comb begin
    in_ready = {N_INPUTS{1'b0}};
    if (!rst && w_win_valid) begin
      in_ready[w_winner] = w_slot_free;
    end else begin
      in_ready = {N_INPUTS{1'b0}};
    end
  end

  // Output register and round-robin pointer; an accept overwrites the slot even while it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data       <= {DWIDTH{1'b0}};
      r_src        <= {SW{1'b0}};
      r_last_grant <= LAST_GRANT_RST;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_win_data;
        r_src   <= w_winner;
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
        r_data  <= r_data;
        r_src   <= r_src;
      end else begin
        r_valid <= r_valid;
        r_data  <= r_data;
        r_src   <= r_src;
      end
      if (w_grant_update) begin
        r_last_grant <= w_winner;
      end else begin
        r_last_grant <= r_last_grant;
      end
    end
  end

endmodule
